// File: rtl/arb_3x1.sv
// Round-robin arbiter for three requesters sharing one resource port.
// Grants are held until done, requester withdrawal, or a hold-limit timeout.
module arb_3x1 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic       done,
   output logic [2:0] grant,
   output logic [1:0] sel,
   output logic       valid,
   output logic       timeout
);

   // state | meaning
   // IDLE  | no grant active, waiting for any request
   // BUSY  | one requester owns the resource, hold counter running

   localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    last;

   logic          pick_any;
   logic [1:0]    pick_idx;
   logic          held;
   logic          hit_limit;
   logic          rel;

   // Search starts just after the previous winner so it gets lowest priority.
   always_comb begin
      pick_any = 1'b0;
      pick_idx = 2'd0;
      for (int k = 1; k <= 3; k++) begin
         logic [1:0] c;
         c = 2'((int'(last) + k) % 3);
         if (!pick_any && req[c]) begin
            pick_any = 1'b1;
            pick_idx = c;
         end
      end
   end

   assign held      = |(grant & req);
   assign hit_limit = (cnt == CNT_LAST);
   assign rel       = done || !held || hit_limit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         grant   <= 3'b000;
         sel     <= 2'b00;
         valid   <= 1'b0;
         timeout <= 1'b0;
         cnt     <= '0;
         last    <= 2'd2;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state <= BUSY;
                  grant <= 3'b001 << pick_idx;
                  sel   <= pick_idx;
                  valid <= 1'b1;
                  last  <= pick_idx;
                  cnt   <= '0;
               end
            end
            BUSY: begin
               if (rel) begin
                  // done takes precedence; abort also suppresses the pulse
                  timeout <= !done && held && hit_limit;
                  cnt     <= '0;
                  if (pick_any) begin
                     grant <= 3'b001 << pick_idx;
                     sel   <= pick_idx;
                     valid <= 1'b1;
                     last  <= pick_idx;
                  end else begin
                     state <= IDLE;
                     grant <= 3'b000;
                     sel   <= 2'b00;
                     valid <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_sel_legal: assert property (@(posedge clk) disable iff (reset) sel != 2'b11);

endmodule

// File: doc/arb_3x1.md
# arb_3x1

Round-robin arbiter sharing one resource port between three requesters. It drives the 2-bit select of the team's 3-way datapath multiplexer, so the resource's input comes from exactly one requester at a time. Each grant is held until the resource signals completion, the requester withdraws, or a hold-limit timeout expires. It sits between the requester blocks (for example, fetch, load/store and a debug port) and a shared memory or bus port.

## Interface
- MAX_HOLD, 16: maximum cycles a single grant may be held; must be ≥ 2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  3  request lines; bit i belongs to requester i.
- done  in  1  resource completion strobe for the current grant.
- grant  out  3  one-hot grant; all zeros when idle.
- sel  out  2  mux select: 2'b00 = req0, 2'b01 = req1, 2'b10 = req2. Never 2'b11.
- valid  out  1  high while a grant is active.
- timeout  out  1  one-cycle pulse when a grant is force-released.

## Operation
- Reset is asynchronous and active-high. It sets grant = 3'b000, sel = 2'b00, valid = 0, timeout = 0, state = IDLE, hold counter = 0, and last = 2, so req0 has first priority.
- All outputs are registered. grant, sel and valid always change together on the same edge.
- Round-robin order: the search starts at (last+1) mod 3 and goes upward with wrap, 0→1→2→0. The first set req bit wins, and last is updated to the winner.
- States:
  - IDLE: valid = 0, grant = 0, sel = 00.
    - If any req bit is set, the arbiter picks a winner, loads grant/sel/valid, clears the counter and moves to BUSY.
    - done is ignored in IDLE.
  - BUSY: grant is held and the counter increments each cycle. A release happens on the first of these conditions:
    - done = 1 → normal release.
    - req[granted] = 0 → abort. No timeout pulse.
    - counter == MAX_HOLD-1 with done = 0 → forced release, and timeout = 1 for the following cycle.
- Behaviour on the release edge:
  - Arbitration runs immediately among the current req bits. The just-released requester has lowest priority because last points to it.
  - If any other bit is set, the new grant loads on the same edge, there is no idle gap, and the state stays BUSY with the counter cleared.
  - If only the released requester is still requesting, it is re-granted.
  - If no bit is set, the state goes to IDLE.
- Simultaneous done and timeout condition: done wins, the release is normal, and there is no timeout pulse.
- Simultaneous done and req[granted] drop: this counts as a normal release.
- Counter width is $clog2(MAX_HOLD). It saturates conceptually at MAX_HOLD-1 and is never allowed to wrap.
- sel is encoded from grant. sel = 2'b11 is unreachable; an assertion in simulation flags it.

## Timing
- Request-to-grant latency is 1 cycle: req sampled high at edge N gives grant/valid high after edge N.
- Release latency is 1 cycle: done sampled at edge N drops or changes the grant after edge N.
- A granted requester sees grant for at least 1 cycle and at most MAX_HOLD cycles.
- The timeout pulse is high for exactly the single cycle following the forced-release edge.
- Back-to-back grants to different requesters are possible every cycle when done is asserted each cycle.
- Reset mid-grant: outputs clear immediately and asynchronously. The in-flight transfer is dropped, and last returns to 2.
- A combinational path from req/done to outputs is forbidden.

## Test plan
- Reset, then req = 3'b111 held and done pulsed every 3rd cycle. Required: grant sequence 001 → 010 → 100 → 001, sel 00 → 01 → 10 → 00, each grant lasting 3 cycles, and valid continuously high.
- Single requester: req = 3'b010, done after 2 cycles, then req = 0. Required: grant = 010 for 2 cycles, then IDLE with grant = 0, sel = 00, valid = 0; timeout never asserted.
- Timeout: MAX_HOLD = 4, req = 3'b001 held, done = 0. Required: grant held 4 cycles, then timeout = 1 for 1 cycle, and req0 re-granted on the same edge because it is the only requester.
- Done on the final hold cycle: MAX_HOLD = 4, done = 1 in cycle 4. Required: normal release with timeout = 0.
- Abort: req = 3'b101, grant = 001, then req0 drops with done = 0. Required: next edge gives grant = 100 and timeout = 0.
- Asynchronous reset asserted mid-grant (grant = 010), between clock edges. Required: grant = 0, sel = 00, valid = 0 immediately. After release with req = 3'b111, the first grant is 001.
